// File: rtl/mux_n_1_arb_if.sv
// ---------------------------------------------------------------------------
// mux_n_1_arb_if
//   Handshake/data bundle for the N:1 registered channel-merge element.
//
//   Signals
//     in_data   [N*W]   channel i occupies bits [i*W +: W]
//     in_valid  [N]     per-channel valid
//     in_ready  [N]     per-channel ready (combinational, from the mux)
//     mode              0 = fixed select, 1 = round-robin
//     sel       [SEL_W] channel index used in fixed mode
//     out_data  [W]     registered output word
//     out_valid         registered output valid
//     out_ready         downstream ready
//     out_ch    [SEL_W] index of the channel held in out_data
//     sel_err           out-of-range select flag
//
//   Modports
//     master : the environment side (drives channels, mode/sel, out_ready)
//     slave  : the mux side (drives in_ready and all out_* signals)
// ---------------------------------------------------------------------------
interface mux_n_1_arb_if #(
    parameter int N     = 3,
    parameter int W     = 1,
    parameter int SEL_W = 2
);
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic [SEL_W-1:0] out_ch;
    logic             sel_err;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch, sel_err
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch, sel_err
    );
endinterface

// File: rtl/mux_n_1_arb.sv
// ---------------------------------------------------------------------------
// mux_n_1_arb
//   Parametrised N-input, W-bit multiplexer with one output register stage
//   and valid/ready handshakes on every input and on the output. The source
//   channel is either fixed by sel (mode=0) or chosen round-robin among the
//   valid inputs (mode=1). Sustains one word per cycle: the output register
//   may drain and reload in the same cycle.
//
//   Ports
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset (synchronous release upstream)
//     bus    slave modport of mux_n_1_arb_if (see interface for signals)
//
//   Parameters
//     N      number of input channels (2..16)
//     W      data width per channel (1..64)
//     SEL_W  width of sel/out_ch, 2**SEL_W >= N
//
//   Build option
//     MUX_ERR_STICKY_EN  when defined, sel_err latches high until reset;
//                        otherwise it pulses for one cycle per offending cycle.
// ---------------------------------------------------------------------------
module mux_n_1_arb #(
    parameter int N     = 3,
    parameter int W     = 1,
    parameter int SEL_W = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_n_1_arb_if.slave  bus
);

    logic [W-1:0]     out_data_reg;
    logic             out_valid_reg;
    logic [SEL_W-1:0] out_ch_reg;
    logic             sel_err_reg;
    logic [SEL_W-1:0] rr_ptr_reg;

    logic             load_en;
    logic             grant_any;
    logic [SEL_W-1:0] grant_idx;
    logic [W-1:0]     grant_data;
    logic             sel_oob;
    logic             err_cond;
    logic [SEL_W-1:0] rr_ptr_next;
    logic [W-1:0]     ch_data [N];

    // rst_n is folded in so that no channel sees ready while reset is held.
    assign load_en = rst_n & (~out_valid_reg | bus.out_ready);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            assign ch_data[gi]      = bus.in_data[gi*W +: W];
            assign bus.in_ready[gi] = load_en & grant_any & (grant_idx == SEL_W'(gi));
        end
    endgenerate

    // Grant selection. A grant implies the granted channel is valid, so
    // load_en & grant_any is exactly "a transfer happens this cycle".
    always_comb begin
        int idx;
        idx        = 0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        sel_oob    = 1'b1;

        for (int i = 0; i < N; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                sel_oob = 1'b0;
            end
        end

        if (!bus.mode) begin
            for (int i = 0; i < N; i++) begin
                if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
                    grant_any  = 1'b1;
                    grant_idx  = SEL_W'(i);
                    grant_data = ch_data[i];
                end
            end
        end else begin
            // Scan from the far end back towards rr_ptr so the hit closest
            // to rr_ptr is the last one written and therefore wins.
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(rr_ptr_reg) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (bus.in_valid[idx]) begin
                    grant_any  = 1'b1;
                    grant_idx  = SEL_W'(idx);
                    grant_data = ch_data[idx];
                end
            end
        end
    end

    // Explicit wrap so non-power-of-2 N never leaves rr_ptr out of range.
    assign rr_ptr_next = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);
    assign err_cond    = ~bus.mode & sel_oob & load_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_ch_reg    <= '0;
            sel_err_reg   <= 1'b0;
            rr_ptr_reg    <= '0;
        end else begin
            if (load_en && grant_any) begin
                out_data_reg  <= grant_data;
                out_ch_reg    <= grant_idx;
                out_valid_reg <= 1'b1;
                if (bus.mode) begin
                    rr_ptr_reg <= rr_ptr_next;
                end
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end

`ifdef MUX_ERR_STICKY_EN
            if (err_cond) begin
                sel_err_reg <= 1'b1;
            end
`else
            sel_err_reg <= err_cond;
`endif
        end
    end

    assign bus.out_data  = out_data_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_ch    = out_ch_reg;
    assign bus.sel_err   = sel_err_reg;

endmodule
